lcd_bus_receiver: RTL and testbench

- Responder end of the 8-bit parallel character-LCD bus driven by `lcd_controller`.
- Samples `lcd_data`, register-select and `lcd_enable` and commits one transaction per falling edge of enable.
- Decodes HD44780-style commands and data writes into a 2x16 character buffer, and models controller busy time.
- Used as the on-FPGA display model for bring-up and as the checker target in controller benches.

---
 rtl/lcd_bus_receiver.sv | 149 ++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_receiver.sv
// Responder model of an 8-bit HD44780-style character LCD bus: synchronizes the
// bus, commits one transaction per enable fall, keeps a 2x16 buffer and models busy time.
module lcd_bus_receiver #(
   parameter int CMD_BUSY_CYCLES   = 37,
   parameter int CLEAR_BUSY_CYCLES = 1520
) (
   input  logic       fpga_clk_i,
   input  logic       fpga_reset_i,
   input  logic [7:0] lcd_data_i,
   input  logic       lcd_rs_i,
   input  logic       lcd_enable_i,
   input  logic       rd_line_i,
   input  logic [3:0] rd_col_i,
   output logic [7:0] rd_char_o,
   output logic       cursor_line_o,
   output logic [3:0] cursor_col_o,
   output logic       busy_o,
   output logic       valid_o,
   output logic       overrun_o
);

   localparam int MAX_CYC = (CLEAR_BUSY_CYCLES > CMD_BUSY_CYCLES) ? CLEAR_BUSY_CYCLES
                                                                   : CMD_BUSY_CYCLES;
   localparam int CW = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] CMD_LOAD = CW'(CMD_BUSY_CYCLES);
   localparam logic [CW-1:0] CLR_LOAD = CW'(CLEAR_BUSY_CYCLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_BUSY
   } state_t;

   state_t        r_state;
   logic [9:0]    r_sync1;
   logic [9:0]    r_sync2;
   logic          r_en3;
   logic [4:0]    r_idx;
   logic [CW-1:0] r_cnt;
   logic [4:0]    r_cur;      // {line, col}: +1/-1 on this gives the line wrap for free
   logic          r_dir_inc;
   logic          r_overrun;
   logic [7:0]    r_rd_char;
   logic [7:0]    r_mem [32];

   logic          w_fall;
   logic          w_rs;
   logic [7:0]    w_data;
   logic          w_idle;
   logic          w_accept;

   // Enable, rs and data travel together through the same two stages.
   always_ff @(posedge fpga_clk_i or posedge fpga_reset_i) begin
      if (fpga_reset_i) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_en3   <= 1'b0;
      end else begin
         // NOTE: non-blocking so every stage samples the previous cycle's value.
         r_sync1 <= {lcd_enable_i, lcd_rs_i, lcd_data_i};
         r_sync2 <= r_sync1;
         r_en3   <= r_sync2[9];
      end
   end

   assign w_fall   = r_en3 & ~r_sync2[9];
   assign w_rs     = r_sync2[8];
   assign w_data   = r_sync2[7:0];
   assign w_idle   = (r_state == S_IDLE);
   assign w_accept = w_fall & w_idle;

   always_ff @(posedge fpga_clk_i or posedge fpga_reset_i) begin
      if (fpga_reset_i) begin
         r_state   <= S_CLEAR;
         r_idx     <= '0;
         r_cnt     <= CLR_LOAD;
         r_cur     <= '0;
         r_dir_inc <= 1'b1;
         r_overrun <= 1'b0;
      end else begin
         if (w_fall && !w_idle) r_overrun <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_fall) begin
                  r_state <= S_BUSY;
                  r_cnt   <= CMD_LOAD;
                  if (w_rs) begin
                     r_cur <= r_dir_inc ? r_cur + 5'd1 : r_cur - 5'd1;
                  end else begin
                     casez (w_data)
                        8'b0000_0001: begin
                           r_state   <= S_CLEAR;
                           r_idx     <= '0;
                           r_cnt     <= CLR_LOAD;
                           r_cur     <= '0;
                           r_dir_inc <= 1'b1;
                        end
                        8'b0000_001?: begin
                           r_cnt <= CLR_LOAD;
                           r_cur <= '0;
                        end
                        8'b0000_01??: r_dir_inc <= w_data[1];
                        8'b1???_????: begin
                           if (w_data[6:4] == 3'b000)      r_cur <= {1'b0, w_data[3:0]};
                           else if (w_data[6:4] == 3'b100) r_cur <= {1'b1, w_data[3:0]};
                        end
                        default: ;
                     endcase
                  end
               end
            end
            S_CLEAR: begin
               r_idx <= r_idx + 5'd1;
               r_cnt <= r_cnt - CNT_ONE;
               if (r_idx == 5'd31) r_state <= (r_cnt == CNT_ONE) ? S_IDLE : S_BUSY;
            end
            S_BUSY: begin
               if (r_cnt <= CNT_ONE) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // NOTE: the character array has no reset; the post-reset clear sweep initializes it.
   always_ff @(posedge fpga_clk_i) begin
      if (r_state == S_CLEAR)  r_mem[r_idx] <= 8'h20;
      else if (w_accept && w_rs) r_mem[r_cur] <= w_data;
   end

   always_ff @(posedge fpga_clk_i or posedge fpga_reset_i) begin
      if (fpga_reset_i) r_rd_char <= 8'h00;
      else              r_rd_char <= r_mem[{rd_line_i, rd_col_i}];
   end

   assign rd_char_o     = r_rd_char;
   assign cursor_line_o = r_cur[4];
   assign cursor_col_o  = r_cur[3:0];
   assign busy_o        = ~w_idle;
   assign valid_o       = w_accept;
   assign overrun_o     = r_overrun;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: bus transactions, busy timing, overrun,
// and read-back through a queue of expected characters.
module tb_lcd_bus_receiver;

   localparam int CMD_N = 37;
   localparam int CLR_N = 1520;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] lcd_data = 8'h00;
   logic       lcd_rs = 1'b0;
   logic       lcd_en = 1'b0;
   logic       rd_line = 1'b0;
   logic [3:0] rd_col = 4'd0;
   logic [7:0] rd_char;
   logic       cur_line;
   logic [3:0] cur_col;
   logic       busy;
   logic       valid;
   logic       overrun;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] exp_q [$];

   lcd_bus_receiver #(
      .CMD_BUSY_CYCLES  (CMD_N),
      .CLEAR_BUSY_CYCLES(CLR_N)
   ) dut (
      .fpga_clk_i   (clk),
      .fpga_reset_i (rst),
      .lcd_data_i   (lcd_data),
      .lcd_rs_i     (lcd_rs),
      .lcd_enable_i (lcd_en),
      .rd_line_i    (rd_line),
      .rd_col_i     (rd_col),
      .rd_char_o    (rd_char),
      .cursor_line_o(cur_line),
      .cursor_col_o (cur_col),
      .busy_o       (busy),
      .valid_o      (valid),
      .overrun_o    (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cursor(input string tag, input logic line, input logic [3:0] col);
      chk({tag, " line"}, 32'(cur_line), 32'(line));
      chk({tag, " col"}, 32'(cur_col), 32'(col));
   endtask

   task automatic read_cell(input logic line, input logic [3:0] col, input logic [7:0] exp);
      logic [7:0] e;
      rd_line = line;
      rd_col  = col;
      exp_q.push_back(exp);
      tick();
      e = exp_q.pop_front();
      chk($sformatf("rd(%0d,%0d)", line, col), 32'(rd_char), 32'(e));
   endtask

   task automatic read_all_blank(input string tag);
      for (int l = 0; l < 2; l++)
         for (int c = 0; c < 16; c++)
            read_cell(l[0], c[3:0], 8'h20);
      $display("%s: buffer scan done", tag);
   endtask

   task automatic pulse_en(input logic rs, input logic [7:0] d);
      lcd_rs   = rs;
      lcd_data = d;
      lcd_en   = 1'b1;
      repeat (3) tick();
      lcd_en   = 1'b0;
   endtask

   task automatic wait_valid(output bit seen);
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
         tick();
         if (valid) seen = 1'b1;
      end
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < 5000) begin
         n++;
         tick();
      end
   endtask

   task automatic xfer(input string tag, input logic rs, input logic [7:0] d, input int exp_busy);
      bit seen;
      int n;
      pulse_en(rs, d);
      wait_valid(seen);
      chk({tag, " valid"}, 32'(seen), 32'd1);
      if (seen) begin
         tick();
         chk({tag, " valid width"}, 32'(valid), 32'd0);
         count_busy(n);
         chk({tag, " busy len"}, 32'(n), 32'(exp_busy));
      end
   endtask

   initial begin
      bit seen;
      bit extra;
      int n;

      // Reset values
      repeat (3) tick();
      chk("rst busy", 32'(busy), 32'd1);
      chk("rst valid", 32'(valid), 32'd0);
      chk("rst overrun", 32'(overrun), 32'd0);
      chk("rst rd_char", 32'(rd_char), 32'd0);
      chk_cursor("rst cursor", 1'b0, 4'd0);
      rst = 1'b0;
      count_busy(n);
      chk("post-reset busy len", 32'(n), 32'(CLR_N));
      chk_cursor("post-reset cursor", 1'b0, 4'd0);
      read_all_blank("post-reset");

      // Two data writes with increment
      xfer("wr A", 1'b1, 8'h41, CMD_N);
      xfer("wr B", 1'b1, 8'h42, CMD_N);
      read_cell(1'b0, 4'd0, 8'h41);
      read_cell(1'b0, 4'd1, 8'h42);
      chk_cursor("after AB", 1'b0, 4'd2);

      // Address 0x4F, then wrap through the end of line 1
      xfer("cmd CF", 1'b0, 8'hCF, CMD_N);
      chk_cursor("after CF", 1'b1, 4'd15);
      xfer("wr 5A", 1'b1, 8'h5A, CMD_N);
      chk_cursor("after 5A", 1'b0, 4'd0);
      xfer("wr 5B", 1'b1, 8'h5B, CMD_N);
      chk_cursor("after 5B", 1'b0, 4'd1);
      read_cell(1'b1, 4'd15, 8'h5A);
      read_cell(1'b0, 4'd0, 8'h5B);
      read_cell(1'b0, 4'd1, 8'h42);

      // Decrement mode wraps backwards from (0,0)
      xfer("cmd 04", 1'b0, 8'h04, CMD_N);
      xfer("cmd 80", 1'b0, 8'h80, CMD_N);
      chk_cursor("after 80", 1'b0, 4'd0);
      xfer("wr 31", 1'b1, 8'h31, CMD_N);
      read_cell(1'b0, 4'd0, 8'h31);
      chk_cursor("after 31", 1'b1, 4'd15);

      // Clear, then a second transaction while busy is dropped
      pulse_en(1'b0, 8'h01);
      wait_valid(seen);
      chk("clear valid", 32'(seen), 32'd1);
      repeat (5) tick();
      pulse_en(1'b1, 8'h77);
      extra = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (valid) extra = 1'b1;
      end
      chk("dropped no valid", 32'(extra), 32'd0);
      chk("overrun set", 32'(overrun), 32'd1);
      count_busy(n);
      chk("clear finishes", 32'(n < 5000), 32'd1);
      chk("overrun sticky", 32'(overrun), 32'd1);
      chk_cursor("after clear", 1'b0, 4'd0);
      read_all_blank("after clear");

      // Clear restored increment; invalid address leaves cursor; home
      xfer("wr X", 1'b1, 8'h58, CMD_N);
      chk_cursor("after X", 1'b0, 4'd1);
      xfer("cmd 90", 1'b0, 8'h90, CMD_N);
      chk_cursor("after 90", 1'b0, 4'd1);
      xfer("cmd home", 1'b0, 8'h02, CLR_N);
      chk_cursor("after home", 1'b0, 4'd0);
      read_cell(1'b0, 4'd0, 8'h58);

      // Reset in the middle of a busy period
      pulse_en(1'b1, 8'h66);
      wait_valid(seen);
      chk("wr 66 valid", 32'(seen), 32'd1);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      chk("mid rst overrun", 32'(overrun), 32'd0);
      chk("mid rst busy", 32'(busy), 32'd1);
      chk_cursor("mid rst cursor", 1'b0, 4'd0);
      rst = 1'b0;
      count_busy(n);
      chk("restart clear busy len", 32'(n), 32'(CLR_N));
      chk("overrun after restart", 32'(overrun), 32'd0);
      read_all_blank("after restart");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
